// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: time-multiplexed scan controller for a 4-digit display.
// Cycles a 2-bit select code {A,B} through digits 0..3. Each digit is shown
// for PRESCALE cycles. The matching nibble is presented on digit.
// New digit sets arrive over a valid/ready handshake into a shadow buffer.
// The shadow buffer is copied to the active set only at a frame boundary,
// so a frame is never torn.
// Optional feature: define SCAN_BLANK_EN to build a GUARD state. GUARD
// blanks digit_valid for BLANK_CYCLES between every pair of slots.
module digit_scan_ctrl #(
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  output logic        A,
  output logic        B,
  output logic [3:0]  digit,
  output logic        digit_valid,
  output logic        frame_done
);

  // One counter times both the show slot and the guard gap.
  // It is sized to cover whichever of the two spans is longer.
  localparam int CNT_RANGE = (PRESCALE > BLANK_CYCLES + 1) ? PRESCALE : BLANK_CYCLES + 1;
  localparam int CW        = $clog2(CNT_RANGE);
  localparam logic [CW-1:0] LAST_SHOW = CW'(PRESCALE - 1);
`ifdef SCAN_BLANK_EN
  localparam logic [CW-1:0] LAST_GUARD = CW'(BLANK_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHOW  = 2'd1,
    S_GUARD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    index_q, index_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   active_q, active_d;
  logic          full_q, full_d;
  logic          a_d, b_d, valid_d, frame_done_d;
  logic [3:0]    digit_d;

  assign load_ready = ~full_q;

  // Next-state logic: load handshake, frame-boundary transfer and scan sequencing.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path through
    // this block can leave a value unassigned and infer a latch.
    state_d  = state_q;
    index_d  = index_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    full_d   = full_q;

    // Accept a load only while the shadow is empty.
    // A transfer needs full_q set, so an accept and a transfer never happen together.
    if (load_valid && !full_q) begin
      shadow_d = load_data;
      full_d   = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        index_d = 2'd0;
        cnt_d   = '0;
        if (enable) begin
          state_d = S_SHOW;
          if (full_q) begin
            active_d = shadow_q;
            full_d   = 1'b0;
          end
        end
      end

      S_SHOW: begin
        if (!enable) begin
          state_d = S_IDLE;
          index_d = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q == LAST_SHOW) begin
          if (index_q == 2'd3 && full_q) begin
            active_d = shadow_q;
            full_d   = 1'b0;
          end
          index_d = index_q + 2'd1;
          cnt_d   = '0;
`ifdef SCAN_BLANK_EN
          state_d = S_GUARD;
`else
          state_d = S_SHOW;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

`ifdef SCAN_BLANK_EN
      S_GUARD: begin
        if (!enable) begin
          state_d = S_IDLE;
          index_d = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q == LAST_GUARD) begin
          state_d = S_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        index_d = 2'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output look-ahead: compute next-cycle outputs so that select, data and strobes are registered together.
  always_comb begin
    a_d          = index_d[1];
    b_d          = index_d[0];
    valid_d      = (state_d == S_SHOW);
    digit_d      = (state_d == S_IDLE) ? 4'd0 : active_d[{index_d, 2'b00} +: 4];
    frame_done_d = (state_d == S_SHOW) && (index_d == 2'd3) && (cnt_d == LAST_SHOW);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every register
    // then samples pre-edge values, whatever the statement order.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      index_q     <= 2'd0;
      cnt_q       <= '0;
      // NOTE: the digit buffers are cleared explicitly. Pending shadow data must
      // not survive a reset, and IDLE is expected to present a zero digit.
      shadow_q    <= 16'd0;
      active_q    <= 16'd0;
      full_q      <= 1'b0;
      A           <= 1'b0;
      B           <= 1'b0;
      digit       <= 4'd0;
      digit_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      full_q      <= full_d;
      A           <= a_d;
      B           <= b_d;
      digit       <= digit_d;
      digit_valid <= valid_d;
      frame_done  <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed testbench for digit_scan_ctrl with PRESCALE = 4 and BLANK_CYCLES = 2.
// Expectations follow SCAN_BLANK_EN: when it is defined, every show slot is
// followed by two blanked guard cycles.
module tb_digit_scan_ctrl;

  localparam int PRESCALE     = 4;
  localparam int BLANK_CYCLES = 2;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        A;
  logic        B;
  logic [3:0]  digit;
  logic        digit_valid;
  logic        frame_done;

  int total_cnt;
  int pass_cnt;
  int fail_cnt;

  digit_scan_ctrl #(
    .PRESCALE    (PRESCALE),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .A          (A),
    .B          (B),
    .digit      (digit),
    .digit_valid(digit_valid),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check(tag, {15'd0, obs}, {15'd0, exp});
  endtask

  task automatic check_nib(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    check(tag, {12'd0, obs}, {12'd0, exp});
  endtask

  // Check one displayed cycle of slot idx.
  task automatic check_show(input logic [1:0] idx, input logic [3:0] dig, input logic fd);
    check_bit($sformatf("show%0d A", idx), A, idx[1]);
    check_bit($sformatf("show%0d B", idx), B, idx[0]);
    check_bit($sformatf("show%0d digit_valid", idx), digit_valid, 1'b1);
    check_nib($sformatf("show%0d digit", idx), digit, dig);
    check_bit($sformatf("show%0d frame_done", idx), frame_done, fd);
  endtask

  // Guard cycles that follow slot idx, when blanking is built.
  task automatic guard_after(input logic [1:0] idx);
`ifdef SCAN_BLANK_EN
    logic [1:0] nxt;
    nxt = idx + 2'd1;
    for (int g = 0; g < BLANK_CYCLES; g++) begin
      check_bit("guard digit_valid", digit_valid, 1'b0);
      check_bit("guard A", A, nxt[1]);
      check_bit("guard B", B, nxt[0]);
      check_bit("guard frame_done", frame_done, 1'b0);
      tick();
    end
`else
    check_bit("abut digit_valid", digit_valid, 1'b1);
`endif
  endtask

  // A complete slot: PRESCALE shown cycles, then the guard gap when blanking is built.
  task automatic run_slot(input logic [1:0] idx, input logic [3:0] dig);
    for (int c = 0; c < PRESCALE; c++) begin
      check_show(idx, dig, (idx == 2'd3) && (c == PRESCALE - 1));
      tick();
    end
    guard_after(idx);
  endtask

  task automatic check_idle(input string tag);
    check_bit({tag, " A"}, A, 1'b0);
    check_bit({tag, " B"}, B, 1'b0);
    check_bit({tag, " digit_valid"}, digit_valid, 1'b0);
    check_bit({tag, " frame_done"}, frame_done, 1'b0);
  endtask

  initial begin
    total_cnt  = 0;
    pass_cnt   = 0;
    fail_cnt   = 0;
    rst_n      = 1'b0;
    enable     = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'd0;

    // Reset: two cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      enable     = 1'($urandom_range(0, 1));
      load_valid = 1'($urandom_range(0, 1));
      load_data  = 16'($urandom);
      tick();
    end
    check_idle("reset");
    check_nib("reset digit", digit, 4'd0);
    check_bit("reset load_ready", load_ready, 1'b1);

    // Load 0x4321 while idle.
    rst_n      = 1'b1;
    enable     = 1'b0;
    load_valid = 1'b1;
    load_data  = 16'h4321;
    tick();
    load_valid = 1'b0;
    check_bit("idle load ready_low", load_ready, 1'b0);
    check_idle("idle after load");

    // Enable: display starts on the next cycle, and the transfer frees the shadow.
    enable = 1'b1;
    tick();
    check_bit("start load_ready", load_ready, 1'b1);

    // Frame 1: digits 1..4.
    run_slot(2'd0, 4'd1);
    run_slot(2'd1, 4'd2);
    run_slot(2'd2, 4'd3);
    run_slot(2'd3, 4'd4);

    // Frame 2: load 0x8765 during the index-1 slot; this frame stays 1..4.
    run_slot(2'd0, 4'd1);
    check_show(2'd1, 4'd2, 1'b0);
    load_valid = 1'b1;
    load_data  = 16'h8765;
    tick();
    load_valid = 1'b0;
    check_bit("db ready_low", load_ready, 1'b0);
    for (int c = 1; c < PRESCALE; c++) begin
      check_show(2'd1, 4'd2, 1'b0);
      tick();
    end
    guard_after(2'd1);
    // This offer arrives while the shadow is full, so it must be ignored.
    load_valid = 1'b1;
    load_data  = 16'hFFFF;
    run_slot(2'd2, 4'd3);
    load_valid = 1'b0;
    check_bit("db still_full", load_ready, 1'b0);
    run_slot(2'd3, 4'd4);
    check_bit("db ready_back", load_ready, 1'b1);

    // Frame 3: new set 5..8.
    run_slot(2'd0, 4'd5);
    run_slot(2'd1, 4'd6);
    run_slot(2'd2, 4'd7);
    run_slot(2'd3, 4'd8);

    // Enable drop in the 3rd cycle of the index-2 slot.
    run_slot(2'd0, 4'd5);
    run_slot(2'd1, 4'd6);
    check_show(2'd2, 4'd7, 1'b0);
    tick();
    check_show(2'd2, 4'd7, 1'b0);
    tick();
    check_show(2'd2, 4'd7, 1'b0);
    enable = 1'b0;
    tick();
    check_idle("drop");
    tick();
    check_idle("drop hold");
    enable = 1'b1;
    tick();
    run_slot(2'd0, 4'd5);
    run_slot(2'd1, 4'd6);
    run_slot(2'd2, 4'd7);
    run_slot(2'd3, 4'd8);

    // Mid-frame reset with 0x8765 pending: the pending set must never appear.
    run_slot(2'd0, 4'd5);
    check_show(2'd1, 4'd6, 1'b0);
    load_valid = 1'b1;
    load_data  = 16'h8765;
    tick();
    load_valid = 1'b0;
    check_bit("mrst pending", load_ready, 1'b0);
    check_show(2'd1, 4'd6, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle("mrst");
    check_nib("mrst digit", digit, 4'd0);
    check_bit("mrst load_ready", load_ready, 1'b1);
    tick();
    run_slot(2'd0, 4'd0);
    run_slot(2'd1, 4'd0);
    run_slot(2'd2, 4'd0);
    run_slot(2'd3, 4'd0);
    check_bit("mrst ready_end", load_ready, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
